bus_controller: RTL

BUS_CONTROLLER -- requirements
Module: bus_controller

---
 rtl/bus_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//
// Two-requester bus master. It arbitrates between two requesters and then runs
// one four-phase bus cycle (T1..T4) against a pair of memory banks that are
// selected by address bit 19.
//
// Parameters
//   ARB_MODE  1 = round-robin between the requesters, 0 = fixed priority
//             (requester 0 wins).
//
// Ports
//   CLK            rising-edge clock
//   RESET          asynchronous reset, active low
//   REQ[1:0]       per-requester transaction request
//   WE[1:0]        per-requester direction (1 = write, 0 = read)
//   IOM_IN[1:0]    per-requester memory/IO qualifier
//   ADDR0, ADDR1   requester target addresses (20 bit)
//   WDATA0, WDATA1 requester write data (8 bit)
//   RDATA          data of the last completed read
//   DONE[1:0]      one-cycle completion pulse, per requester (T4)
//   BUSY           high whenever a bus cycle is in progress
//   ALE            address latch enable, T1 only
//   RD, WR         active-low read/write strobes, T2 and T3
//   IOM            memory/IO qualifier of the current transaction
//   CS0, CS1       bank chip selects, T1..T3
//   Address        bus address (0 while idle)
//   Data           bidirectional bus data, driven only during a write's T2/T3
// -----------------------------------------------------------------------------
module bus_controller #(
  parameter int unsigned ARB_MODE = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WE,
  input  logic [1:0]  IOM_IN,
  input  logic [19:0] ADDR0,
  input  logic [19:0] ADDR1,
  input  logic [7:0]  WDATA0,
  input  logic [7:0]  WDATA1,
  output logic [7:0]  RDATA,
  output logic [1:0]  DONE,
  output logic        BUSY,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic        CS0,
  output logic        CS1,
  output logic [19:0] Address,
  inout  wire  [7:0]  Data
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  state_t      state, state_next;

  // Transaction registers, loaded at the accepting edge.
  logic        tr_id;
  logic        tr_we;
  logic        tr_iom;
  logic [19:0] tr_addr;
  logic [7:0]  tr_wdata;

  logic        last_id;     // requester served most recently
  logic        grant_id;
  logic        accept;
  logic        drive_data;

  // Requests are only looked at in IDLE; a request that goes away during a bus
  // cycle therefore cannot disturb it.
  assign accept = (state == IDLE) && (REQ != 2'b00);

  always_comb begin
    grant_id = 1'b0;
    case (REQ)
      2'b10:   grant_id = 1'b1;
      // Contended: round-robin hands the bus to whoever was not served last.
      2'b11:   grant_id = (ARB_MODE != 0) ? ~last_id : 1'b0;
      default: grant_id = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the transaction registers are small and are reset along with the
  // FSM, so nothing downstream ever sees an unknown address or direction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tr_id    <= 1'b0;
      tr_we    <= 1'b0;
      tr_iom   <= 1'b0;
      tr_addr  <= '0;
      tr_wdata <= '0;
      last_id  <= 1'b1;   // requester 0 wins the first contested grant
    end else if (accept) begin
      tr_id    <= grant_id;
      tr_we    <= WE[grant_id];
      tr_iom   <= IOM_IN[grant_id];
      tr_addr  <= grant_id ? ADDR1 : ADDR0;
      tr_wdata <= grant_id ? WDATA1 : WDATA0;
      last_id  <= grant_id;
    end
  end

  // Read data is sampled from the bus at the edge that ends T3.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RDATA <= '0;
    end else if ((state == T3) && !tr_we) begin
      RDATA <= Data;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    BUSY       = 1'b1;
    ALE        = 1'b0;
    RD         = 1'b1;
    WR         = 1'b1;
    CS0        = 1'b0;
    CS1        = 1'b0;
    IOM        = tr_iom;
    Address    = tr_addr;
    DONE       = 2'b00;
    drive_data = 1'b0;

    case (state)
      IDLE: begin
        BUSY    = 1'b0;
        IOM     = 1'b0;
        Address = '0;
        if (REQ != 2'b00) state_next = T1;
      end
      T1: begin
        ALE        = 1'b1;
        CS0        = ~tr_addr[19];
        CS1        = tr_addr[19];
        state_next = T2;
      end
      T2, T3: begin
        CS0        = ~tr_addr[19];
        CS1        = tr_addr[19];
        RD         = tr_we;
        WR         = ~tr_we;
        drive_data = tr_we;
        state_next = (state == T2) ? T3 : T4;
      end
      T4: begin
        DONE       = tr_id ? 2'b10 : 2'b01;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Data = drive_data ? tr_wdata : 8'hzz;

endmodule
